pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch-stage controller owning the program counter and the instruction-memory request handshake. Each cycle it takes the MEM-stage redirect decision (PCSource, branch and jump targets) and the hazard unit's stall. It sequences fetches into the IF/ID register and flushes younger stages on a redirect. A redirect that lands while a memory request is in flight is handled by completing that request and discarding its data.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
- CNT_W, 16, width of the redirect counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- PCSource  in  2  from the MEM stage: 0 = sequential, 1 = branch, 2 = jump, 3 = treated as 0
- PC_branch  in  32  branch target, used when PCSource=1
- PC_jump  in  32  jump target, used when PCSource=2
- stall  in  1  hazard-unit stall; freezes IF/ID and PC advance
- imem_req  out  1  instruction-memory request valid
- imem_addr  out  32  request address, equals pc
- imem_ready  in  1  memory accepts the request and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_req & imem_ready
- if_valid  out  1  IF/ID register holds a live instruction
- if_instr  out  32  IF/ID instruction
- if_pc  out  32  IF/ID instruction address
- flush  out  1  combinational; kill IF/ID, ID/EX and EX/MEM
- redirect_cnt  out  CNT_W  saturating count of redirect cycles

## Operation
- redirect = PCSource is 1 or 2. target = PC_branch or PC_jump, with bits [1:0] forced to 0. flush = redirect.
- Handshake: once imem_req is high and imem_ready is low, imem_req stays high and imem_addr stays stable until the request is accepted. accept = imem_req & imem_ready.
- States:
  - RST: held during reset.
  - FETCH: no request in flight.
  - WAIT: request in flight; data will be kept.
  - DRAIN: request in flight; data will be discarded.
  - HELD: data captured in the skid register while stall is high.
- RST -> FETCH on the first clk after rst falls.
- FETCH: imem_req = !stall & !redirect.
  - On redirect: pc <= target.
  - On accept: load if_*, pc <= pc+4, stay in FETCH.
  - On req & !ready: go to WAIT.
- WAIT: imem_req = 1.
  - Redirect with ready: discard data, pc <= target, go to FETCH.
  - Redirect with !ready: pending <= target, go to DRAIN.
  - Ready & !stall: load if_*, pc <= pc+4, go to FETCH.
  - Ready & stall: skid <= rdata, go to HELD.
- DRAIN: imem_req = 1 at the old pc.
  - A further redirect overwrites pending.
  - On ready: discard data, pc <= pending (or the current cycle's target if redirect is also high), go to FETCH.
- HELD: imem_req = 0.
  - On redirect: drop the skid, pc <= target, go to FETCH.
  - Else, when stall falls: load if_* from the skid and pc, pc <= pc+4, go to FETCH.
- IF/ID update rules, in priority order:
  - A redirect clears if_valid at the next edge; if_instr and if_pc hold.
  - Otherwise stall holds all if_* outputs.
  - Otherwise a load writes if_valid=1, if_instr, if_pc.
  - Otherwise, with no load, if_valid <= 0 (bubble).
- Redirect has priority over stall.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- redirect_cnt increments on each redirect cycle and saturates at all-ones.

## Timing
- Reset values: pc=RESET_PC, state=RST, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, redirect_cnt=0. flush follows PCSource even during reset.
- Reset mid-request: the in-flight request is abandoned; the memory must tolerate imem_req dropping on reset.
- First request: imem_req rises in the first cycle in FETCH, i.e. one cycle after rst deasserts.
- Zero-wait memory (imem_ready tied 1, no stall): one instruction per cycle, if_pc sequence RESET_PC, +4, +8, ...
- Latency:
  - A fetch accepted at edge N shows on if_* after edge N.
  - A redirect in cycle N: the target address is requested in cycle N+1 from FETCH.
  - If a request is in flight, the target is requested in the cycle after the accept of the discarded request.
- A redirect during reset is ignored.

## Test plan
- Reset release, RESET_PC=0, ready=1 -> imem_addr 0,4,8,C in consecutive cycles; if_pc follows one cycle later; if_valid=1 from the 2nd cycle after release.
- Branch: PCSource=1, PC_branch=0x40 in cycle N with ready=1 -> flush=1 in N; if_valid=0 after N; imem_addr=0x40 in N+1; redirect_cnt=1.
- Jump during WAIT: ready low 3 cycles at addr 0x10, PCSource=2, PC_jump=0x200 in the first of them -> addr held at 0x10 until ready; 0x10 data never appears on if_*; next request at 0x200.
- Stall during WAIT: ready arrives with stall=1 for 2 cycles -> state HELD, imem_req=0, if_* frozen; one cycle after stall falls, if_instr = the captured word and the next request is pc+4.
- Redirect and stall in the same cycle in FETCH -> redirect wins: pc=target, if_valid=0, no request that cycle.
- Wrap and saturation: RESET_PC=0xFFFFFFF8, ready=1 -> addresses FFFFFFF8, FFFFFFFC, 0. With CNT_W=2, 5 redirects -> redirect_cnt=3.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns the program counter, drives the instruction
// memory request handshake, fills the IF/ID register and flushes younger
// stages on a MEM-stage redirect.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       PCSource,
   input  logic [31:0]      PC_branch,
   input  logic [31:0]      PC_jump,
   input  logic             stall,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic             if_valid,
   output logic [31:0]      if_instr,
   output logic [31:0]      if_pc,
   output logic             flush,
   output logic [CNT_W-1:0] redirect_cnt
);

   typedef enum logic [2:0] {
      S_RST,
      S_FETCH,
      S_WAIT,
      S_DRAIN,
      S_HELD
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] skid_q, skid_d;
   logic        load;
   logic [31:0] load_instr;
   logic        redirect;
   logic [31:0] target;

   assign redirect  = (PCSource == 2'd1) || (PCSource == 2'd2);
   assign target    = ((PCSource == 2'd2) ? PC_jump : PC_branch) & 32'hFFFF_FFFC;
   assign flush     = redirect;
   assign imem_addr = pc_q;

   // Next-state, request and IF/ID load decision for the fetch sequencer.
   // A request already on the bus must complete at its address, so a
   // redirect during WAIT either retires it immediately (ready) or parks the
   // target in pend until the discarded request is accepted.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      skid_d     = skid_q;
      imem_req   = 1'b0;
      load       = 1'b0;
      load_instr = imem_rdata;
      unique case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            imem_req = !stall && !redirect;
            if (redirect) begin
               pc_d = target;
            end else if (!stall) begin
               if (imem_ready) begin
                  load = 1'b1;
                  pc_d = pc_q + 32'd4;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            imem_req = 1'b1;
            if (redirect) begin
               if (imem_ready) begin
                  pc_d    = target;
                  state_d = S_FETCH;
               end else begin
                  pend_d  = target;
                  state_d = S_DRAIN;
               end
            end else if (imem_ready) begin
               if (stall) begin
                  skid_d  = imem_rdata;
                  state_d = S_HELD;
               end else begin
                  load    = 1'b1;
                  pc_d    = pc_q + 32'd4;
                  state_d = S_FETCH;
               end
            end
         end
         S_DRAIN: begin
            imem_req = 1'b1;
            if (redirect) pend_d = target;
            if (imem_ready) begin
               pc_d    = redirect ? target : pend_q;
               state_d = S_FETCH;
            end
         end
         S_HELD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = S_FETCH;
            end else if (!stall) begin
               load       = 1'b1;
               load_instr = skid_q;
               pc_d       = pc_q + 32'd4;
               state_d    = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Sequencer state, program counter, pending target and skid register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RST;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         skid_q  <= skid_d;
      end
   end

   // IF/ID register: redirect kills, stall holds, load fills, else bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc    <= '0;
      end else if (redirect) begin
         if_valid <= 1'b0;
      end else if (stall) begin
         if_valid <= if_valid;
      end else if (load) begin
         if_valid <= 1'b1;
         if_instr <= load_instr;
         if_pc    <= pc_q;
      end else begin
         if_valid <= 1'b0;
      end
   end

   // Saturating count of cycles with a redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_cnt <= '0;
      end else if (redirect && (redirect_cnt != '1)) begin
         redirect_cnt <= redirect_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, wrap/saturation sequence
// on a second instance, and random stimulus against a transaction model.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  PCSource = 2'd0;
   logic [31:0] PC_branch = '0;
   logic [31:0] PC_jump = '0;
   logic        stall = 1'b0;
   logic        imem_ready = 1'b1;
   logic        imem_req, imem_req2;
   logic [31:0] imem_addr, imem_addr2;
   logic [31:0] imem_rdata, imem_rdata2;
   logic        if_valid, if_valid2;
   logic [31:0] if_instr, if_instr2;
   logic [31:0] if_pc, if_pc2;
   logic        flush, flush2;
   logic [15:0] redirect_cnt;
   logic [1:0]  redirect_cnt2;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_5EED;
   endfunction

   assign imem_rdata  = mem_word(imem_addr);
   assign imem_rdata2 = mem_word(imem_addr2);

   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst), .PCSource(PCSource), .PC_branch(PC_branch),
      .PC_jump(PC_jump), .stall(stall), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .flush(flush), .redirect_cnt(redirect_cnt)
   );

   pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .PCSource(PCSource), .PC_branch(PC_branch),
      .PC_jump(PC_jump), .stall(stall), .imem_req(imem_req2),
      .imem_addr(imem_addr2), .imem_ready(imem_ready), .imem_rdata(imem_rdata2),
      .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
      .flush(flush2), .redirect_cnt(redirect_cnt2)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
   endtask

   task automatic drive(input logic [1:0] src, input logic [31:0] tgt, input logic st, input logic rd);
      PCSource   = src;
      PC_branch  = (src == 2'd1) ? tgt : 32'hBAD0_0004;
      PC_jump    = (src == 2'd2) ? tgt : 32'hDEAD_BEE0;
      stall      = st;
      imem_ready = rd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Directed vectors: inputs for one cycle and the outputs expected in it.
   typedef struct {
      logic [1:0]  src;
      logic [31:0] tgt;
      logic        st;
      logic        rd;
      logic        req;
      logic [31:0] addr;
      logic        fl;
      logic        v;
      logic [31:0] ifpc;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[21];

   // Transaction-level reference model.
   bit          m_started, m_busy, m_drop, m_held, m_v;
   logic [31:0] m_pc, m_pend, m_skid, m_instr, m_ifpc;
   logic [15:0] m_cnt;

   task automatic model_reset();
      m_started = 0; m_busy = 0; m_drop = 0; m_held = 0; m_v = 0;
      m_pc = 32'h0; m_pend = '0; m_skid = '0; m_instr = '0; m_ifpc = '0; m_cnt = '0;
   endtask

   function automatic bit model_req(input bit redir);
      if (!m_started || m_held) return 0;
      if (m_busy) return 1;
      return !stall && !redir;
   endfunction

   task automatic model_step();
      bit redir, ld, req;
      logic [31:0] tgt, li, lp;
      redir = (PCSource == 2'd1) || (PCSource == 2'd2);
      tgt   = ((PCSource == 2'd2) ? PC_jump : PC_branch) & ~32'h3;
      req   = model_req(redir);
      ld = 0; li = mem_word(m_pc); lp = m_pc;
      if (!m_started) begin
         m_started = 1;
      end else if (m_held) begin
         if (redir) begin
            m_held = 0; m_pc = tgt;
         end else if (!stall) begin
            ld = 1; li = m_skid; m_pc = m_pc + 4; m_held = 0;
         end
      end else if (m_busy && m_drop) begin
         if (redir) m_pend = tgt;
         if (imem_ready) begin
            m_pc = m_pend; m_busy = 0; m_drop = 0;
         end
      end else if (m_busy) begin
         if (redir && imem_ready) begin
            m_pc = tgt; m_busy = 0;
         end else if (redir) begin
            m_pend = tgt; m_drop = 1;
         end else if (imem_ready && !stall) begin
            ld = 1; m_pc = m_pc + 4; m_busy = 0;
         end else if (imem_ready) begin
            m_skid = mem_word(m_pc); m_held = 1; m_busy = 0;
         end
      end else begin
         if (redir) m_pc = tgt;
         else if (req) begin
            if (imem_ready) begin
               ld = 1; m_pc = m_pc + 4;
            end else begin
               m_busy = 1;
            end
         end
      end
      if (redir) m_v = 0;
      else if (stall) m_v = m_v;
      else if (ld) begin
         m_v = 1; m_instr = li; m_ifpc = lp;
      end else m_v = 0;
      if (redir && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(2'd0, 32'h0, 1'b0, 1'b1);
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      vecs = '{
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b1 & 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   16'd0},
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 32'h0,   16'd0},
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h4,   1'b0, 1'b1, 32'h0,   16'd0},
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h8,   1'b0, 1'b1, 32'h4,   16'd0},
         '{2'd1, 32'h41,  1'b0, 1'b1, 1'b0, 32'hC,   1'b1, 1'b1, 32'h8,   16'd0},
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h40,  1'b0, 1'b0, 32'h8,   16'd1},
         '{2'd0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h44,  1'b0, 1'b1, 32'h40,  16'd1},
         '{2'd2, 32'h200, 1'b0, 1'b0, 1'b1, 32'h44,  1'b1, 1'b0, 32'h40,  16'd1},
         '{2'd0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h44,  1'b0, 1'b0, 32'h40,  16'd2},
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h44,  1'b0, 1'b0, 32'h40,  16'd2},
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h40,  16'd2},
         '{2'd0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h204, 1'b0, 1'b1, 32'h200, 16'd2},
         '{2'd0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 1'b0, 32'h200, 16'd2},
         '{2'd0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h204, 1'b0, 1'b0, 32'h200, 16'd2},
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h204, 1'b0, 1'b0, 32'h200, 16'd2},
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h208, 1'b0, 1'b1, 32'h204, 16'd2},
         '{2'd1, 32'h300, 1'b1, 1'b1, 1'b0, 32'h20C, 1'b1, 1'b1, 32'h208, 16'd2},
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h208, 16'd3},
         '{2'd0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h304, 1'b0, 1'b1, 32'h300, 16'd3},
         '{2'd3, 32'h500, 1'b0, 1'b1, 1'b1, 32'h304, 1'b0, 1'b1, 32'h300, 16'd3},
         '{2'd0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h308, 1'b0, 1'b1, 32'h304, 16'd3}
      };

      // Reset values; flush follows PCSource even in reset.
      rst = 1'b1;
      drive(2'd1, 32'h80, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_flush", flush, 1'b1);
      chk("rst_valid", if_valid, 1'b0);
      chk("rst_instr", if_instr, 32'h0);
      chk("rst_ifpc", if_pc, 32'h0);
      chk("rst_cnt", redirect_cnt, 16'd0);
      chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);
      @(negedge clk);
      rst = 1'b0;

      // Directed table, first row is the cycle right after reset release.
      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].src, vecs[i].tgt, vecs[i].st, vecs[i].rd);
         #1;
         chk($sformatf("v%0d_req", i), imem_req, vecs[i].req);
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
         chk($sformatf("v%0d_flush", i), flush, vecs[i].fl);
         chk($sformatf("v%0d_valid", i), if_valid, vecs[i].v);
         chk($sformatf("v%0d_ifpc", i), if_pc, vecs[i].ifpc);
         chk($sformatf("v%0d_cnt", i), redirect_cnt, vecs[i].cnt);
         if (vecs[i].v) chk($sformatf("v%0d_instr", i), if_instr, mem_word(vecs[i].ifpc));
         next_cycle();
      end

      // PC wrap on the second instance, then counter saturation at CNT_W=2.
      do_reset();
      begin
         logic [31:0] wexp[5];
         logic        wreq[5];
         wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
         wreq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
         for (int i = 0; i < 5; i++) begin
            drive(2'd0, 32'h0, 1'b0, 1'b1);
            #1;
            chk($sformatf("wrap%0d_addr", i), imem_addr2, wexp[i]);
            chk($sformatf("wrap%0d_req", i), imem_req2, wreq[i]);
            next_cycle();
         end
      end
      for (int i = 0; i < 5; i++) begin
         drive(2'd2, 32'h100, 1'b0, 1'b1);
         next_cycle();
      end
      drive(2'd0, 32'h0, 1'b0, 1'b1);
      #1;
      chk("sat_cnt2", redirect_cnt2, 2'd3);
      chk("cnt16_after5", redirect_cnt, 16'd5);
      chk("redir_addr2", imem_addr2, 32'h100);
      next_cycle();

      // Random stimulus against the model, with one reset mid-run.
      do_reset();
      model_reset();
      for (int i = 0; i < 1200; i++) begin
         int unsigned r;
         logic [1:0] src;
         logic [127:0] got, exp;
         if (i == 600) begin
            drive(2'd0, 32'h0, 1'b0, 1'b0);
            #2;
            rst = 1'b1;
            next_cycle();
            rst = 1'b0;
            model_reset();
         end
         r = $urandom_range(0, 9);
         src = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         if (!m_started) src = 2'd0;
         drive(src, $urandom & 32'h0000_FFFF, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
         #1;
         got = {13'd0, imem_req, flush, if_valid, imem_addr, if_pc, if_instr, redirect_cnt};
         exp = {13'd0, model_req(PCSource == 2'd1 || PCSource == 2'd2),
                PCSource == 2'd1 || PCSource == 2'd2, m_v, m_pc, m_ifpc, m_instr, m_cnt};
         chk($sformatf("rand%0d", i), got, exp);
         model_step();
         next_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
